cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Consumer end of the ALU decoder's ALUControl/FlagW interface in the single-cycle ARM control unit.
- Holds the architectural NZCV flag registers and updates them per FlagW.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the PC-select, register-write and memory-write strobes so only instructions whose condition passes commit state.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into {N,Z,C,V} on reset.
- NV_EXECUTES, 0, cond=4'b1111 handling: 0 = never execute, 1 = execute as AL.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  1 = hold flags, force all gated strobes to 0 this cycle.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
- FlagW  input  2  from ALU decoder: [1] writes N,Z; [0] writes C,V.
- PCS  input  1  ungated PC-write request (branch or Rd==PC).
- RegW  input  1  ungated register-file write request.
- MemW  input  1  ungated data-memory write request.
- NoWrite  input  1  1 = compare-type op (CMP/CMN/TST); suppresses register write.
- PCSrc  output  1  gated PC select.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition-pass result, combinational from Cond and stored flags.
- Flags  output  4  stored {N,Z,C,V}, registered.

Behaviour:
- Reset (reset_n low, async): Flags = RESET_FLAGS immediately. Combinational outputs follow from the reset flags and the current inputs. The reset default gives CondEx=1 for AL.
- Flag storage: two independent registers, NZ = Flags[3:2] and CV = Flags[1:0]. Each updates only at the rising clk edge.
- NZ write enable = FlagW[1] & CondEx & ~Stall. Loads ALUFlags[3:2].
- CV write enable = FlagW[0] & CondEx & ~Stall. Loads ALUFlags[1:0].
- An instruction that fails its condition never alters flags.
- Condition evaluation uses stored Flags only, never the incoming ALUFlags. A flag-setting instruction affects conditions from the next instruction (next cycle) onward.
- CondEx decode by Cond:
  - 0000 EQ: Z; 0001 NE: ~Z
  - 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N
  - 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: NV_EXECUTES
- Gated strobes, all combinational, zero latency:
  - PCSrc = PCS & CondEx & ~Stall
  - RegWrite = RegW & CondEx & ~NoWrite & ~Stall
  - MemWrite = MemW & CondEx & ~Stall
- FlagW=2'b00 (ALUOp low, or S bit clear): flags hold regardless of CondEx.
- FlagW=2'b10 (logical op): only NZ updates; C,V keep their previous values.
- Stall high: flags hold and strobes are 0. CondEx still reflects the evaluation.
- reset_n asserted mid-cycle: flags clear at once, with no wait for clk. A flag write due at that edge is lost. The first edge after release behaves normally.
- No X-propagation: every output has a defined value for all input combinations.

Test Plan:
- Reset: reset_n=0 with ALUFlags=4'b1111, FlagW=11, clk toggling -> Flags=0000 throughout. Release -> next edge Flags=1111.
- ADDS then BEQ: cycle 1 Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 after edge. Cycle 2 Cond=0000, PCS=1 -> CondEx=1, PCSrc=1.
- Failed condition: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1001, RegW=1, MemW=1 -> CondEx=0, RegWrite=0, MemWrite=0, Flags stay 0000 after edge.
- Logical partial write: Flags=0011, Cond=1110, FlagW=10, ALUFlags=1000 -> Flags=1011 after edge (C,V preserved).
- CMP with GE/LT: NoWrite=1, RegW=1, FlagW=11, ALUFlags=1001 -> RegWrite=0, Flags=1001. Next cycle Cond=1010 -> CondEx=1; Cond=1011 -> CondEx=0.
- Stall and NV: Stall=1, Cond=1110, FlagW=11, ALUFlags=0110, PCS=RegW=MemW=1 -> all strobes 0, Flags unchanged. Stall=0, Cond=1111, NV_EXECUTES=0 -> CondEx=0.

Source files
------------

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Conditional-execution stage of the single-cycle ARM control unit. It holds
// the architectural NZCV flags and evaluates the instruction's condition field
// against them. The PC-select, register-write and memory-write requests are
// gated so that only instructions whose condition passes can commit state.
//
// Parameters
//   RESET_FLAGS : value loaded into {N,Z,C,V} while reset_n is low
//   NV_EXECUTES : behaviour of cond 4'b1111 (0 = never execute, 1 = like AL)
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   Stall     in   hold flags and force every gated strobe to 0
//   Cond      in   [3:0] condition field, Instr[31:28]
//   ALUFlags  in   [3:0] ALU result flags {N,Z,C,V}
//   FlagW     in   [1:0] flag write request: [1] N,Z  [0] C,V
//   PCS       in   ungated PC-write request
//   RegW      in   ungated register-file write request
//   MemW      in   ungated data-memory write request
//   NoWrite   in   compare-type op, suppresses the register write
//   PCSrc     out  gated PC select
//   RegWrite  out  gated register write
//   MemWrite  out  gated memory write
//   CondEx    out  condition-pass result (from the stored flags)
//   Flags     out  [3:0] stored {N,Z,C,V}
// -----------------------------------------------------------------------------
module cond_logic #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Stall,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  // Condition decode over the stored flags {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [3:0] flags,
                                     input logic       nv_exec);
    logic n;
    logic z;
    logic c;
    logic v;
    logic r;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      4'b1111: r = nv_exec;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [1:0] nz_r;
  logic [1:0] cv_r;
  logic       cond_ex_s;
  logic       nz_we_s;
  logic       cv_we_s;

  // Condition evaluation and write enables; all combinational from stored flags.
  always_comb begin
    cond_ex_s = cond_pass({nz_r, cv_r}, 4'b0000, 1'b0);
    cond_ex_s = cond_pass(Cond, {nz_r, cv_r}, NV_EXECUTES);
    nz_we_s   = FlagW[1] & cond_ex_s & ~Stall;
    cv_we_s   = FlagW[0] & cond_ex_s & ~Stall;
  end

  // N,Z flag register; a logical op may update it without touching C,V.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nz_r <= RESET_FLAGS[3:2];
    end else if (nz_we_s) begin
      nz_r <= ALUFlags[3:2];
    end else begin
      nz_r <= nz_r;
    end
  end

  // C,V flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv_r <= RESET_FLAGS[1:0];
    end else if (cv_we_s) begin
      cv_r <= ALUFlags[1:0];
    end else begin
      cv_r <= cv_r;
    end
  end

  // Strobes are gated with zero latency so the same-cycle commit is suppressed.
  assign CondEx   = cond_ex_s;
  assign PCSrc    = PCS  & cond_ex_s & ~Stall;
  assign RegWrite = RegW & cond_ex_s & ~NoWrite & ~Stall;
  assign MemWrite = MemW & cond_ex_s & ~Stall;
  assign Flags    = {nz_r, cv_r};

endmodule

// File: tb/tb_cond_logic.sv
// -----------------------------------------------------------------------------
// tb_cond_logic
// Bench for cond_logic: directed scenarios with literal expectations followed
// by randomized traffic, all checked against an architectural flag/condition
// model held in the bench.
// -----------------------------------------------------------------------------
module tb_cond_logic;

  localparam logic [3:0] RST_FLAGS = 4'b0000;
  localparam bit         NV_EXEC   = 1'b0;

  logic       clk;
  logic       reset_n;
  logic       Stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] mflags;

  cond_logic #(.RESET_FLAGS(RST_FLAGS), .NV_EXECUTES(NV_EXEC)) dut (
    .clk(clk), .reset_n(reset_n), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: conditions come in pairs, odd code = inverse of even;
  // 111x is the always / never-or-always pair.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    if (cond[3:1] == 3'd7) return cond[0] ? NV_EXEC : 1'b1;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ cond[0];
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic ce;
    ce = model_cond(Cond, mflags);
    chk("CondEx",   {3'b000, CondEx},   {3'b000, ce});
    chk("PCSrc",    {3'b000, PCSrc},    {3'b000, PCS && ce && !Stall});
    chk("RegWrite", {3'b000, RegWrite}, {3'b000, RegW && ce && !NoWrite && !Stall});
    chk("MemWrite", {3'b000, MemWrite}, {3'b000, MemW && ce && !Stall});
    chk("Flags",    Flags,              mflags);
  endtask

  task automatic apply(input logic st, input logic [3:0] cd, input logic [3:0] af,
                       input logic [1:0] fw, input logic p, input logic r,
                       input logic m, input logic nw);
    Stall = st; Cond = cd; ALUFlags = af; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw;
    #1;
  endtask

  // Compare at the falling edge, advance the model, then move past the rising edge.
  task automatic cycle();
    logic ce;
    @(negedge clk);
    compare_all();
    ce = model_cond(Cond, mflags);
    if (reset_n && ce && !Stall) begin
      if (FlagW[1]) mflags[3:2] = ALUFlags[3:2];
      if (FlagW[0]) mflags[1:0] = ALUFlags[1:0];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    apply(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    mflags = RST_FLAGS;
    // Reset held across edges with a pending full flag write.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_flags", Flags, 4'b0000);
      chk("reset_condex_al", {3'b000, CondEx}, 4'b0001);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("release_load", Flags, 4'b1111);
    mflags = 4'b1111;

    // ADDS then BEQ.
    apply(1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("adds_flags", Flags, 4'b0100);
    apply(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_condex", {3'b000, CondEx}, 4'b0001);
    chk("beq_pcsrc", {3'b000, PCSrc}, 4'b0001);
    cycle();

    // Failed condition must not write flags or commit.
    apply(1'b0, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    apply(1'b0, 4'b0000, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("eq_fail_condex", {3'b000, CondEx}, 4'b0000);
    chk("eq_fail_regwrite", {3'b000, RegWrite}, 4'b0000);
    chk("eq_fail_memwrite", {3'b000, MemWrite}, 4'b0000);
    cycle();
    chk("eq_fail_flags", Flags, 4'b0000);

    // Logical op updates only N,Z.
    apply(1'b0, 4'b1110, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    apply(1'b0, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("logical_partial", Flags, 4'b1011);

    // CMP then GE / LT.
    apply(1'b0, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cmp_regwrite", {3'b000, RegWrite}, 4'b0000);
    cycle();
    chk("cmp_flags", Flags, 4'b1001);
    apply(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ge_pass", {3'b000, CondEx}, 4'b0001);
    apply(1'b0, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lt_fail", {3'b000, CondEx}, 4'b0000);
    cycle();

    // Stall, then NV.
    apply(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("stall_condex", {3'b000, CondEx}, 4'b0001);
    chk("stall_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
    cycle();
    chk("stall_flags", Flags, 4'b1001);
    apply(1'b0, 4'b1111, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("nv_condex", {3'b000, CondEx}, 4'b0000);
    cycle();
    chk("nv_flags", Flags, 4'b1001);

    // Mid-cycle async reset drops the pending write.
    apply(1'b0, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_clear", Flags, 4'b0000);
    mflags = RST_FLAGS;
    @(posedge clk); #1;
    chk("reset_edge_lost", Flags, 4'b0000);
    reset_n = 1'b1;
    cycle();
    chk("post_release", Flags, 4'b0110);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 7) == 0, 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        #1;
        mflags = RST_FLAGS;
        chk("rand_async_clear", Flags, RST_FLAGS);
        reset_n = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
